// File: rtl/systola_pkg.sv
// Shared constants and state encoding for the systolic array sequencer.
package systola_pkg;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 32;

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_e;
endpackage

// File: rtl/skew_line.sv
// Fixed-depth delay chain with async reset and synchronous clear.
// DEPTH of 0 is a plain wire from i_d to o_q.
module skew_line #(
  parameter int DEPTH = 0,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  generate
    if (DEPTH == 0) begin : g_pass
      logic w_unused;
      assign w_unused = clk ^ rst_n ^ i_clr;
      assign o_q = i_d;
    end else begin : g_pipe
      logic [DEPTH-1:0][W-1:0] r_pipe;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_pipe <= '0;
        end else if (i_clr) begin
          r_pipe <= '0;
        end else begin
          r_pipe[0] <= i_d;
          for (int s = 1; s < DEPTH; s++) r_pipe[s] <= r_pipe[s-1];
        end
      end
      assign o_q = r_pipe[DEPTH-1];
    end
  endgenerate
endmodule

// File: rtl/systolic_seq.sv
// Operand sequencer for an N x N output-stationary systolic array: reads K
// operand columns, skews them onto the array edges and signals completion.
// Optional SYSTOLA_PERF_CNT_EN adds run_cnt / busy_cyc performance counters.
module systolic_seq
  import systola_pkg::*;
#(
  parameter int N   = 4,
  parameter int K_W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic [K_W-1:0]            k_len,
  output logic                      busy,
  output logic                      done,
  output logic                      rd_en,
  output logic [K_W-1:0]            rd_addr,
  input  logic [N-1:0][DATA_W-1:0]  a_rdata,
  input  logic [N-1:0][DATA_W-1:0]  b_rdata,
  output logic [N-1:0]              row_fire,
  output logic [N-1:0][DATA_W-1:0]  row_data,
  output logic [N-1:0][DATA_W-1:0]  col_weight
`ifdef SYSTOLA_PERF_CNT_EN
  ,
  output logic [15:0]               run_cnt,
  output logic [31:0]               busy_cyc
`endif
);
  localparam int DW = $clog2(2 * N);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(2 * N - 1);

  state_e         r_state, w_state_nx;
  logic [K_W-1:0] r_klen, w_klen_nx;
  logic [K_W-1:0] r_cnt, w_cnt_nx;
  logic [K_W-1:0] r_rd_addr, w_rd_addr_nx;
  logic           r_rd_en, w_rd_en_nx;
  logic [DW-1:0]  r_drain, w_drain_nx;
  logic           r_vld;
  logic           w_abort_run;

  logic [N-1:0][DATA_W-1:0] w_a_in, w_b_in;

  assign w_abort_run = abort && (r_state == S_FEED || r_state == S_DRAIN);

  // FEED spends its first cycle priming, then issues one read per cycle;
  // r_cnt reaching r_klen means the last read (K-1) has gone out.
  always_comb begin
    w_state_nx   = r_state;
    w_klen_nx    = r_klen;
    w_cnt_nx     = r_cnt;
    w_rd_en_nx   = 1'b0;
    w_rd_addr_nx = '0;
    w_drain_nx   = r_drain;
    unique case (r_state)
      S_IDLE: begin
        if (start && !abort && k_len != '0) begin
          w_state_nx = S_FEED;
          w_klen_nx  = k_len;
          w_cnt_nx   = '0;
        end
      end
      S_FEED: begin
        if (r_cnt == r_klen) begin
          w_state_nx = S_DRAIN;
          w_drain_nx = DRAIN_LAST;
        end else begin
          w_rd_en_nx   = 1'b1;
          w_rd_addr_nx = r_cnt;
          w_cnt_nx     = r_cnt + 1'b1;
        end
      end
      S_DRAIN: begin
        if (r_drain == '0) w_state_nx = S_DONE;
        else               w_drain_nx = r_drain - 1'b1;
      end
      S_DONE: w_state_nx = S_IDLE;
    endcase
    if (w_abort_run) begin
      w_state_nx   = S_IDLE;
      w_rd_en_nx   = 1'b0;
      w_rd_addr_nx = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_klen    <= '0;
      r_cnt     <= '0;
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
      r_drain   <= '0;
      r_vld     <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_klen    <= w_klen_nx;
      r_cnt     <= w_cnt_nx;
      r_rd_en   <= w_rd_en_nx;
      r_rd_addr <= w_rd_addr_nx;
      r_drain   <= w_drain_nx;
      r_vld     <= w_abort_run ? 1'b0 : r_rd_en;
    end
  end

  assign busy    = (r_state != S_IDLE);
  assign done    = (r_state == S_DONE);
  assign rd_en   = r_rd_en;
  assign rd_addr = r_rd_addr;

  // r_vld marks buffer data returning this cycle; gating keeps idle lanes at 0.
  for (genvar i = 0; i < N; i++) begin : g_lane
    assign w_a_in[i] = r_vld ? a_rdata[i] : '0;
    assign w_b_in[i] = r_vld ? b_rdata[i] : '0;

    skew_line #(.DEPTH(i), .W(DATA_W)) u_row (
      .clk(clk), .rst_n(rst_n), .i_clr(w_abort_run), .i_d(w_a_in[i]), .o_q(row_data[i])
    );
    skew_line #(.DEPTH(i), .W(DATA_W)) u_col (
      .clk(clk), .rst_n(rst_n), .i_clr(w_abort_run), .i_d(w_b_in[i]), .o_q(col_weight[i])
    );
    skew_line #(.DEPTH(i), .W(1)) u_fire (
      .clk(clk), .rst_n(rst_n), .i_clr(w_abort_run), .i_d(r_vld), .o_q(row_fire[i])
    );
  end

`ifdef SYSTOLA_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt  <= '0;
      busy_cyc <= '0;
    end else begin
      if (busy) busy_cyc <= busy_cyc + 1'b1;
      if (done && run_cnt != 16'hFFFF) run_cnt <= run_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_systolic_seq.sv
// Directed bench for systolic_seq: operand buffer model plus an N x N
// output-stationary PE array model fed from the skewed edge outputs.
module tb_systolic_seq;
  import systola_pkg::*;
  localparam int N   = 4;
  localparam int K_W = 8;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [K_W-1:0] k_len = '0;
  logic busy, done, rd_en;
  logic [K_W-1:0] rd_addr;
  logic [N-1:0][DATA_W-1:0] a_rdata = '0, b_rdata = '0;
  logic [N-1:0] row_fire;
  logic [N-1:0][DATA_W-1:0] row_data, col_weight;
`ifdef SYSTOLA_PERF_CNT_EN
  logic [15:0] run_cnt;
  logic [31:0] busy_cyc;
`endif

  systolic_seq #(.N(N), .K_W(K_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .k_len(k_len),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
    .a_rdata(a_rdata), .b_rdata(b_rdata), .row_fire(row_fire),
    .row_data(row_data), .col_weight(col_weight)
`ifdef SYSTOLA_PERF_CNT_EN
    , .run_cnt(run_cnt), .busy_cyc(busy_cyc)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // operand buffers: a_mem[k][i] = A[i][k], b_mem[k][j] = B[k][j]
  logic [N-1:0][DATA_W-1:0] a_mem [256];
  logic [N-1:0][DATA_W-1:0] b_mem [256];
  always @(posedge clk) if (rd_en) begin
    a_rdata <= a_mem[rd_addr];
    b_rdata <= b_mem[rd_addr];
  end

  // PE array model; accumulator restarts on the rising edge of its fire input
  logic [DATA_W-1:0] pa [N][N];
  logic [DATA_W-1:0] pb [N][N];
  logic              pf [N][N];
  logic signed [ACC_W-1:0] acc [N][N];

  function automatic logic [DATA_W-1:0] a_in(input int i, input int j);
    if (j == 0) return row_data[i];
    return pa[i][j-1];
  endfunction
  function automatic logic f_in(input int i, input int j);
    if (j == 0) return row_fire[i];
    return pf[i][j-1];
  endfunction
  function automatic logic [DATA_W-1:0] b_in(input int i, input int j);
    if (i == 0) return col_weight[j];
    return pb[i-1][j];
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) begin
      if (!rst_n) begin
        pa[i][j] <= '0; pb[i][j] <= '0; pf[i][j] <= 1'b0; acc[i][j] <= '0;
      end else begin
        pa[i][j] <= a_in(i, j);
        pb[i][j] <= b_in(i, j);
        pf[i][j] <= f_in(i, j);
        if (f_in(i, j))
          acc[i][j] <= (pf[i][j] ? acc[i][j] : 32'sd0) + $signed(a_in(i, j)) * $signed(b_in(i, j));
      end
    end
  end

  int checks = 0, errors = 0;
  int t0, done_at, rd_first, rd_cnt, addr_bad, fire_tot;
  int fire_first [N];
  int fire_cnt [N];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load_ident();
    for (int k = 0; k < 256; k++) for (int i = 0; i < N; i++) begin
      a_mem[k][i] = (i == k) ? 8'd1 : 8'd0;
      b_mem[k][i] = (k < 3) ? 8'(k * 4 + i + 1) : 8'd0;
    end
  endtask

  task automatic load_const(input logic [7:0] v);
    for (int k = 0; k < 256; k++) for (int i = 0; i < N; i++) begin
      a_mem[k][i] = v;
      b_mem[k][i] = v;
    end
  endtask

  task automatic start_run(input logic [K_W-1:0] k);
    @(negedge clk); start = 1'b1; k_len = k;
    @(posedge clk); #1; t0 = cyc; start = 1'b0; k_len = '0;
  endtask

  task automatic watch(input int limit);
    done_at = -1; rd_first = -1; rd_cnt = 0; addr_bad = 0; fire_tot = 0;
    for (int i = 0; i < N; i++) begin fire_first[i] = -1; fire_cnt[i] = 0; end
    for (int c = 0; c < limit && done_at < 0; c++) begin
      @(negedge clk);
      if (rd_en) begin
        if (rd_cnt == 0) rd_first = cyc;
        if (int'(rd_addr) != rd_cnt) addr_bad++;
        rd_cnt++;
      end
      for (int i = 0; i < N; i++) if (row_fire[i]) begin
        if (fire_cnt[i] == 0) fire_first[i] = cyc;
        fire_cnt[i]++;
        fire_tot++;
      end
      if (done) done_at = cyc;
    end
  endtask

  initial begin
    int cnt;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_row_fire", row_fire, 0);
    check("rst_row_data", row_data, 0);
    check("rst_col_weight", col_weight, 0);
    rst_n = 1'b1;

    // identity A, K=3
    load_ident();
    start_run(3);
    check("r1_busy_t0", busy, 1);
    watch(40);
    check("r1_done_at", done_at, t0 + 12);
    check("r1_rd_first", rd_first, t0 + 1);
    check("r1_rd_cnt", rd_cnt, 3);
    check("r1_addr_bad", addr_bad, 0);
    for (int i = 0; i < N; i++) begin
      check($sformatf("r1_fire_first%0d", i), fire_first[i], t0 + 2 + i);
      check($sformatf("r1_fire_cnt%0d", i), fire_cnt[i], 3);
    end
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++)
      check($sformatf("r1_pe%0d%0d", i, j), acc[i][j], (i < 3) ? i * 4 + j + 1 : 0);
    @(negedge clk);
    check("r1_busy_after", busy, 0);
    check("r1_done_after", done, 0);
`ifdef SYSTOLA_PERF_CNT_EN
    check("perf_run_cnt", run_cnt, 1);
    check("perf_busy_cyc", busy_cyc, 13);
`endif

    // k_len=0 is not a run
    @(negedge clk); start = 1'b1; k_len = '0;
    @(negedge clk); start = 1'b0;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy || rd_en || row_fire != '0) cnt++;
    end
    check("k0_activity", cnt, 0);

    // abort beats start in IDLE
    @(negedge clk); start = 1'b1; k_len = 8'd3; abort = 1'b1;
    @(negedge clk); start = 1'b0; k_len = '0; abort = 1'b0;
    check("abort_start_busy", busy, 0);
    check("abort_start_rd_en", rd_en, 0);

    // back-to-back runs, K=2
    load_const(8'h7F);
    start_run(2);
    watch(40);
    check("b1_done_at", done_at, t0 + 11);
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++)
      check($sformatf("b1_pe%0d%0d", i, j), acc[i][j], 32258);
    load_const(8'h80);
    start_run(2);
    check("b2_busy_t0", busy, 1);
    check("b2_t0", t0, done_at + 2);
    watch(40);
    check("b2_done_at", done_at, t0 + 11);
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++)
      check($sformatf("b2_pe%0d%0d", i, j), acc[i][j], 32768);

    // abort during FEED
    load_ident();
    start_run(8);
    while (cyc < t0 + 4) @(negedge clk);
    abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    check("ab_row_fire", row_fire, 0);
    check("ab_rd_en", rd_en, 0);
    check("ab_busy", busy, 0);
    check("ab_row_data", row_data, 0);
    check("ab_col_weight", col_weight, 0);
    watch(20);
    check("ab_no_done", done_at, -1);
    check("ab_no_fire", fire_tot, 0);
    start_run(3);
    watch(40);
    check("ab_next_done_at", done_at, t0 + 12);
    check("ab_next_pe12", acc[1][2], 7);
    check("ab_next_pe31", acc[3][1], 0);

    // reset mid-DRAIN, then K=1
    start_run(1);
    while (cyc < t0 + 4) @(negedge clk);
    check("rs_fire_pre", row_fire, 4'b0100);
    rst_n = 1'b0;
    #1;
    check("rs_busy", busy, 0);
    check("rs_row_fire", row_fire, 0);
    check("rs_col_weight", col_weight, 0);
    check("rs_rd_en", rd_en, 0);
    @(negedge clk); rst_n = 1'b1;
    start_run(1);
    watch(30);
    check("rs_done_at", done_at, t0 + 10);
    for (int j = 0; j < N; j++)
      check($sformatf("rs_pe0%0d", j), acc[0][j], j + 1);
    check("rs_pe10", acc[1][0], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/systolic_seq.md
SYSTOLIC_SEQ -- requirements
Module: systolic_seq

Interface
REQ-001 Parameter N, default 4, array dimension (N rows x N columns of PEs); legal range 2..16.
REQ-002 Parameter K_W, default 8, width of the accumulation-length field.
REQ-003 clk  input  1  clock; all state rising-edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  run request, sampled in IDLE only.
REQ-006 abort  input  1  synchronous run cancel.
REQ-007 k_len  input  K_W  inner-product length K, sampled with start.
REQ-008 busy  output  1  high from start acceptance through the done cycle.
REQ-009 done  output  1  one-cycle pulse: all N*N PE results latched.
REQ-010 rd_en  output  1  operand buffer read strobe (A and B buffers share it).
REQ-011 rd_addr  output  K_W  operand index k; buffers return data one cycle after rd_en.
REQ-012 a_rdata  input  N*8  signed lane i = A[i][k].
REQ-013 b_rdata  input  N*8  signed lane j = B[k][j].
REQ-014 row_fire  output  N  west-edge fire into row i.
REQ-015 row_data  output  N*8  west-edge data into row i.
REQ-016 col_weight  output  N*8  north-edge weight into column j.

Function
REQ-017 States: IDLE, FEED, DRAIN, DONE; acceptance cycle T0 = first edge with start=1, k_len!=0 in IDLE.
REQ-018 IDLE->FEED at T0; FEED issues rd_en=1, rd_addr=0..K-1 on K consecutive cycles starting T0+1.
REQ-019 FEED->DRAIN after the read with rd_addr=K-1; DRAIN counts 2N-1 cycles, then DONE; DONE->IDLE after one cycle.
REQ-020 Lane i of a_rdata delayed by i cycles drives row_data[i]; lane j of b_rdata delayed by j cycles drives col_weight[j].
REQ-021 row_fire[i] high for exactly K consecutive cycles, starting at T0+2+i, aligned to row_data[i] element k=0.
REQ-022 Skew outputs not carrying a valid element drive 0; row_fire never high outside its window.
REQ-023 done=1 in cycle T0+K+2N+1 (N=4, K=3 -> T0+12); busy falls the cycle after.
REQ-024 start in FEED/DRAIN/DONE ignored; start with k_len=0 ignored, busy stays 0.
REQ-025 Back-to-back: start accepted the cycle after DONE; row_fire guaranteed low >=1 cycle between runs.
REQ-026 abort in FEED/DRAIN: next edge -> IDLE, rd_en=0, all skew registers and row_fire cleared, no done; PE results undefined.
REQ-027 abort concurrent with start in IDLE: abort wins, no acceptance.
REQ-028 rd_addr is k only; no wrap; k_len max 2^K_W-1 legal.

Reset
REQ-029 rst_n low: state=IDLE; busy, done, rd_en, rd_addr, row_fire, row_data, col_weight, all skew stages = 0, asynchronously.
REQ-030 Reset mid-run abandons the run; first start accepted after rst_n release behaves as from power-up.

Configuration
REQ-031 SYSTOLA_PERF_CNT_EN defined: add outputs run_cnt (16 bit, completed runs, saturating) and busy_cyc (32 bit, cycles with busy=1, wrapping), both reset to 0.
REQ-032 SYSTOLA_PERF_CNT_EN undefined: ports and counters absent; all other behaviour identical.

Structure
REQ-033 Package systola_pkg holds DATA_W=8, ACC_W=32, and the state enum type.
REQ-034 Sub-module skew_line: parameterized-depth, parameterized-width delay chain with async reset, clear input; one instance per row lane, column lane, and row_fire bit (depth 0 = passthrough).

Verification
REQ-035 N=4, K=3, A=identity, B rows {1,2,3,4},{5,6,7,8},{9,10,11,12}-> done at T0+12; PE(i,j) results = B[i][j] (i<3), row 3 = 0.
REQ-036 start with k_len=0 -> busy stays 0, no rd_en, no row_fire for 20 cycles.
REQ-037 Two back-to-back runs K=2, A,B all 127 / all -128 -> results 32258 then 32768, each PE sees fire low between runs.
REQ-038 abort at T0+4, K=8 -> all row_fire 0 by T0+5, no done, next start completes normally.
REQ-039 rst_n pulsed low mid-DRAIN -> all outputs 0 immediately; restart K=1 -> done at T0+10 (N=4).
REQ-040 With SYSTOLA_PERF_CNT_EN, three runs K=3, N=4 -> run_cnt=3, busy_cyc=39.
